sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 183 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (address 0) and build timestamp
// (address 1) from an Avalon-MM sysid slave and compares them against
// the expected values. The result is reported through sticky pass and
// timeout flags, and done pulses once at the end of each sequence.
//
// Optional feature (macro SYSID_CHECKER_RETRY_EN): when it is defined, a
// mismatch re-reads both words up to 3 more times before failing.
// The default build, with the macro undefined, fails on the first mismatch.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0,
  parameter logic [31:0] EXPECTED_TS    = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    RD_TS  = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Counter value on the last stalled cycle before a timeout. The counter
  // increments to exactly TIMEOUT_CYCLES on that cycle.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        stall_s;
  logic        match_s;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  assign stall_s = avm_read_q & avm_waitrequest;
  assign match_s = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);

  // Next-state, capture and result logic for the check sequence.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
`ifdef SYSID_CHECKER_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          wait_cnt_d = 16'd0;
`ifdef SYSID_CHECKER_RETRY_EN
          retry_d    = 2'd0;
`endif
          state_d    = RD_ID;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ID, RD_TS: begin
        if (!stall_s) begin
          // Read accepted: an acceptance on the limit cycle is not a timeout.
          wait_cnt_d = 16'd0;
          if (state_q == RD_ID) begin
            id_value_d = avm_readdata;
            state_d    = RD_TS;
          end else begin
            ts_value_d = avm_readdata;
            state_d    = CHECK;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          timeout_d  = 1'b1;
          pass_d     = 1'b0;
          state_d    = FINISH;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      CHECK: begin
        pass_d  = match_s;
        state_d = FINISH;
`ifdef SYSID_CHECKER_RETRY_EN
        if (!match_s && (retry_q != 2'd3)) begin
          retry_d    = retry_q + 2'd1;
          wait_cnt_d = 16'd0;
          state_d    = RD_ID;
        end else begin
          state_d = FINISH;
        end
`endif
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobes and status flags are decoded from the next state so that
  // they leave the flops aligned with the state they belong to.
  always_comb begin
    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS);
    busy_d        = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CHECK);
    done_d        = (state_d == FINISH);
  end

  // State and output registers; reset aborts any read in flight at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 16'd0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= 32'h0;
      ts_value_q    <= 32'h0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef SYSID_CHECKER_RETRY_EN
  // Retry counter for re-reading after a mismatch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_q <= 2'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a small stalling sysid slave model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0;
  localparam logic [31:0] EXP_TS = 32'h5503_6B8A;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  // Slave model configuration
  logic [31:0] slv_id;
  logic [31:0] slv_ts;
  int          stall_cfg;
  int          stall_ctr;

  int checks;
  int errors;
  int addr0_reads;
  logic prev_stall;
  logic prev_addr;

  sysid_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Slave stalls each read for stall_cfg cycles, then accepts it.
  assign avm_waitrequest = avm_read && (stall_ctr < stall_cfg);
  assign avm_readdata    = avm_address ? slv_ts : slv_id;

  always @(posedge clock or posedge reset) begin
    if (reset) stall_ctr <= 0;
    else if (avm_read && avm_waitrequest) stall_ctr <= stall_ctr + 1;
    else stall_ctr <= 0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: address held during stalls, and count of accepted address-0 reads.
  always @(negedge clock) begin
    if (!reset && prev_stall && avm_read) check("addr_hold", {31'd0, avm_address}, {31'd0, prev_addr});
    if (!reset && avm_read && !avm_waitrequest && !avm_address) addr0_reads <= addr0_reads + 1;
    prev_stall <= avm_read & avm_waitrequest;
    prev_addr  <= avm_address;
  end

  // Pulse start, optionally pulse it again at edge count extra_at,
  // and return the cycle in which done appears (start cycle = 1), 0 if never.
  task automatic run_seq(input int extra_at, output int cyc);
    int edges;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 60) begin
      @(posedge clock); #1;
      edges++;
      start = (edges == extra_at);
    end
    start = 1'b0;
    cyc = (done === 1'b1) ? edges + 1 : 0;
  endtask

  int cyc;
  int reads_before;

  initial begin
    checks = 0; errors = 0; addr0_reads = 0;
    prev_stall = 1'b0; prev_addr = 1'b0;
    start = 1'b0; slv_id = EXP_ID; slv_ts = EXP_TS; stall_cfg = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {31'd0, avm_address}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_id", id_value, 32'h0);
    check("rst_ts", ts_value, 32'h0);
    reset = 1'b0;

    // Match, zero wait states
    run_seq(-1, cyc);
    check("match_cycle", cyc, 32'd5);
    check("match_pass", {31'd0, pass}, 32'd1);
    check("match_timeout", {31'd0, timeout}, 32'd0);
    check("match_ts", ts_value, 32'h5503_6B8A);
    check("match_id", id_value, 32'h0);
    check("match_read_fin", {31'd0, avm_read}, 32'd0);
    check("match_busy_fin", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // Three wait states per read
    stall_cfg = 3;
    run_seq(-1, cyc);
    check("wait3_cycle", cyc, 32'd11);
    check("wait3_pass", {31'd0, pass}, 32'd1);

    // Accepted on the cycle the counter reaches the limit: no timeout
    stall_cfg = 7;
    run_seq(-1, cyc);
    check("edge_cycle", cyc, 32'd19);
    check("edge_pass", {31'd0, pass}, 32'd1);
    check("edge_timeout", {31'd0, timeout}, 32'd0);

    // Waitrequest held high: timeout after the 8th stalled cycle
    stall_cfg = 100;
    run_seq(-1, cyc);
    check("to_cycle", cyc, 32'd10);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    check("to_pass", {31'd0, pass}, 32'd0);
    check("to_read", {31'd0, avm_read}, 32'd0);
    @(posedge clock); #1;
    check("to_sticky", {31'd0, timeout}, 32'd1);

    // ID mismatch
    stall_cfg = 0; slv_id = 32'h1;
    reads_before = addr0_reads;
    run_seq(-1, cyc);
    check("mm_pass", {31'd0, pass}, 32'd0);
    check("mm_timeout", {31'd0, timeout}, 32'd0);
    check("mm_id", id_value, 32'h1);
`ifdef SYSID_CHECKER_RETRY_EN
    check("mm_cycle", cyc, 32'd14);
    check("mm_reads", addr0_reads - reads_before, 32'd4);
`else
    check("mm_cycle", cyc, 32'd5);
    check("mm_reads", addr0_reads - reads_before, 32'd1);
`endif

    // Match again so ts_value/pass are nonzero before the reset test
    slv_id = EXP_ID;
    run_seq(-1, cyc);
    check("pre_rst_pass", {31'd0, pass}, 32'd1);

    // Reset during RD_TS
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1;
    check("in_rd_ts_addr", {31'd0, avm_address}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_read", {31'd0, avm_read}, 32'd0);
    check("mid_rst_addr", {31'd0, avm_address}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pass", {31'd0, pass}, 32'd0);
    check("mid_rst_ts", ts_value, 32'h0);
    check("mid_rst_id", id_value, 32'h0);
    repeat (2) begin
      @(posedge clock); #1;
      check("mid_rst_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      check("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    run_seq(-1, cyc);
    check("post_rst_cycle", cyc, 32'd5);
    check("post_rst_pass", {31'd0, pass}, 32'd1);

    // Start pulsed while busy is ignored
    stall_cfg = 3;
    run_seq(3, cyc);
    check("busy_start_cycle", cyc, 32'd11);
    check("busy_start_pass", {31'd0, pass}, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
